conversor_sp_ctrl: RTL and testbench
====================================

# conversor_sp_ctrl

Sequencing controller for the 4-bit serial-to-parallel converter. On a start request it clears the converter and enables exactly WIDTH shift cycles. It then latches the converter's parallel word into an output register and presents it with a valid/ready handshake. It sits between the serial source (which drives D to both converter and controller) and the parallel consumer.

## Interface
Parameters:
- WIDTH, 4, bits per frame; legal range 2..8; bit counter is $clog2(WIDTH+1) bits wide.

Ports:
- clk  input  1  rising-edge clock
- CLR  input  1  asynchronous, active-high reset
- start  input  1  frame request; sampled only in IDLE
- D  input  1  serial line; used by the controller only for the parity bit
- q_in  input  WIDTH  parallel output Q of the converter
- ready  input  1  consumer accepts data_out
- sh_en  output  1  shift enable to the converter
- conv_clr  output  1  one-cycle clear pulse to the converter
- data_out  output  WIDTH  latched word
- valid  output  1  data_out holds an unconsumed word
- busy  output  1  high whenever state != IDLE
- parity_err  output  1  parity result for the current word

## Operation
- Moore FSM with states IDLE, CLEAR, SHIFT, PAR, LOAD, VALID. sh_en, conv_clr and busy decode from state only.
- IDLE: all strobes low. start=1 at an edge moves to CLEAR.
- CLEAR: conv_clr=1 for one cycle. Bit counter is zeroed. Next state is SHIFT.
- SHIFT: sh_en=1. The counter increments each edge. After WIDTH edges, next state is PAR (macro defined) or LOAD.
- PAR: sh_en=0. D is registered as the parity bit at the exiting edge. Next state is LOAD.
- LOAD: at the exiting edge, data_out<=q_in and valid<=1. parity_err is updated. Next state is VALID.
- VALID: valid stays high. ready=1 at an edge clears valid and returns to IDLE. data_out retains its value until the next LOAD.
- start outside IDLE is ignored, including start and ready asserted at the same edge in VALID. That edge completes the handshake, and start must be re-asserted in IDLE.
- ready outside VALID is ignored.
- CLR asserted (any state, asynchronously) forces: state=IDLE, counter=0, sh_en=0, conv_clr=0, data_out=0, valid=0, busy=0, parity_err=0. A frame in progress is abandoned and not resumed.
- Converter model assumed for bench and integration: on clk with sh_en=1, Q<={Q[WIDTH-2:0],D}. conv_clr zeroes Q.

## Timing
- E0 = edge sampling start=1.
- Without parity: CLEAR spans E0–E1. sh_en is high E1–E(WIDTH+1). LOAD spans E(WIDTH+1)–E(WIDTH+2). valid rises after E(WIDTH+2), which is E6 for WIDTH=4.
- With parity: PAR adds one cycle, so valid rises after E(WIDTH+3), which is E7 for WIDTH=4.
- The source must present data bit k (k=0 first) during the k-th sh_en cycle. With parity, it presents the parity bit during the PAR cycle.
- Minimum frame period: WIDTH+4 cycles (no parity) with ready tied high. Back-to-back frames need start in the cycle after VALID exits.

## Configuration
- PARITY_EN defined:
  - PAR state exists and one even-parity bit follows the data.
  - parity_err = ^{q_in, parity_bit}, updated at LOAD and valid with valid.
- PARITY_EN undefined:
  - PAR state is not compiled and SHIFT goes directly to LOAD.
  - parity_err is a constant 0, but the port remains.

## Test plan
- Reset: CLR=1 for 20 ns, mid-clock -> all outputs 0, state IDLE. Asynchronous effect is visible before the next edge.
- Basic frame (no PARITY_EN, WIDTH=4):
  - Stimulus: start pulse, D=1,0,1,0 during the sh_en cycles, ready=0.
  - Required: sh_en high exactly 4 cycles, conv_clr exactly 1 pulse, data_out=4'hA with valid=1 after E6.
  - Then ready=1 for one edge -> valid=0, busy=0.
- Handshake hold: valid held with ready=0 for 10 cycles -> data_out stays 4'hA. start pulses during this time are ignored (busy stays 1, no conv_clr).
- Abort: CLR=1 during the 2nd SHIFT cycle -> immediate IDLE with valid=0.
  - A new frame D=0,1,1,0 then yields data_out=4'h6.
- Parity (PARITY_EN):
  - Frame 4'hA with parity bit 0 -> parity_err=0, valid after E7.
  - Frame 4'hA with parity bit 1 -> parity_err=1.
- Simultaneous: ready=1 and start=1 at the same edge in VALID -> returns to IDLE with no new frame. start on the following edge begins a frame normally.

Source files
------------

// File: rtl/conversor_sp_ctrl.sv
// rtl/conversor_sp_ctrl.sv - sequencing controller for the serial-to-parallel converter
// Optional even-parity bit after the data word is enabled by defining PARITY_EN.
`timescale 1ns/1ps
module conversor_sp_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             start,
  input  logic             D,
  input  logic [WIDTH-1:0] q_in,
  input  logic             ready,
  output logic             sh_en,
  output logic             conv_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
`ifdef PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_LOAD  = 3'd4,
    S_VALID = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

`ifdef PARITY_EN
  logic r_par;
  logic r_perr;
`else
  logic w_unused;
  assign w_unused = D;
`endif

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
`ifdef PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_CLEAR: r_cnt <= '0;
        S_SHIFT: r_cnt <= r_cnt + CW'(1);
`ifdef PARITY_EN
        S_PAR:   r_par <= D;
`endif
        S_LOAD: begin
          r_data  <= q_in;
          r_valid <= 1'b1;
`ifdef PARITY_EN
          r_perr  <= ^{q_in, r_par};
`endif
        end
        S_VALID: if (ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Counter reads WIDTH-1 on the last shift cycle, so the exit edge is the WIDTH-th shift.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_SHIFT;
      S_SHIFT: begin
        if (r_cnt == LAST) begin
`ifdef PARITY_EN
          w_next = S_PAR;
`else
          w_next = S_LOAD;
`endif
        end
      end
`ifdef PARITY_EN
      S_PAR:   w_next = S_LOAD;
`endif
      S_LOAD:  w_next = S_VALID;
      S_VALID: if (ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sh_en    = 1'b0;
    conv_clr = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_CLEAR: conv_clr = 1'b1;
      S_SHIFT: sh_en    = 1'b1;
      default: ;
    endcase
  end

  assign data_out = r_data;
  assign valid    = r_valid;
`ifdef PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_conversor_sp_ctrl.sv
// tb/tb_conversor_sp_ctrl.sv - self-checking bench for conversor_sp_ctrl
`timescale 1ns/1ps
module tb_conversor_sp_ctrl;
  localparam int W = 4;
`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         CLR = 1'b0;
  logic         start = 1'b0;
  logic         D = 1'b0;
  logic [W-1:0] q_in;
  logic         ready = 1'b0;
  logic         sh_en, conv_clr, valid, busy, parity_err;
  logic [W-1:0] data_out;

  int total = 0;
  int bad = 0;
  int n_sh = 0;
  int n_clr = 0;

  conversor_sp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .CLR(CLR), .start(start), .D(D), .q_in(q_in), .ready(ready),
    .sh_en(sh_en), .conv_clr(conv_clr), .data_out(data_out), .valid(valid),
    .busy(busy), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Converter model: clear on conv_clr, otherwise shift D in at the LSB.
  logic [W-1:0] r_q = '0;
  always @(posedge clk) begin
    if (conv_clr) r_q <= '0;
    else if (sh_en) r_q <= {r_q[W-2:0], D};
  end
  assign q_in = r_q;

  always @(negedge clk) begin
    if (sh_en) n_sh++;
    if (conv_clr) n_clr++;
  end

  typedef struct {
    logic [W-1:0] bits;
    logic         pbit;
    int           hold;
    bit           start_in_hold;
    logic [W-1:0] exp_data;
    logic         exp_perr_par;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic model_perr(input logic [W-1:0] bits, input logic pbit);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(bits[i]);
    ones += int'(pbit);
    return (PAR == 1) ? logic'(ones % 2) : 1'b0;
  endfunction

  // Source sends bits MSB first, one per shift cycle, parity bit in the following cycle.
  task automatic run_frame(input logic [W-1:0] bits, input logic pbit,
                           input logic [W-1:0] exp_data, input logic exp_perr, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    n_sh = 0;
    n_clr = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 1 && c <= W) D = bits[W-c];
      else if (c == W + 1) D = pbit;
      else D = 1'b0;
      if (valid === 1'b1) lat = c;
    end
    chk({tag, " latency"}, lat, W + 2 + PAR);
    chk({tag, " sh_en cycles"}, n_sh, W);
    chk({tag, " conv_clr pulses"}, n_clr, 1);
    chk({tag, " data_out"}, {28'd0, data_out}, {28'd0, exp_data});
    chk({tag, " parity_err"}, {31'd0, parity_err}, {31'd0, exp_perr});
  endtask

  task automatic accept(input int hold, input bit pulse_start, input logic [W-1:0] exp_data,
                        input string tag);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start = (pulse_start && (i % 3 == 1)) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, " hold data"}, {28'd0, data_out}, {28'd0, exp_data});
    chk({tag, " hold valid/busy"}, {30'd0, valid, busy}, 32'd3);
    chk({tag, " hold no clear"}, n_clr, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk({tag, " after ready valid/busy"}, {30'd0, valid, busy}, 32'd0);
    chk({tag, " data retained"}, {28'd0, data_out}, {28'd0, exp_data});
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{4'hA, 1'b0, 10, 1'b1, 4'hA, 1'b0};
    vecs[1] = '{4'hA, 1'b1, 0, 1'b0, 4'hA, 1'b1};
    vecs[2] = '{4'h6, 1'b0, 2, 1'b1, 4'h6, 1'b0};
    vecs[3] = '{4'hF, 1'b1, 1, 1'b0, 4'hF, 1'b1};
    vecs[4] = '{4'h1, 1'b0, 0, 1'b0, 4'h1, 1'b1};

    // Reset asserted mid-clock; outputs must clear before any edge.
    #1 CLR = 1'b1;
    #2;
    chk("reset outputs", {24'd0, sh_en, conv_clr, valid, busy, parity_err, 3'd0},
        32'd0);
    chk("reset data_out", {28'd0, data_out}, 32'd0);
    #18 CLR = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].bits, vecs[i].pbit, vecs[i].exp_data,
                (PAR == 1) ? vecs[i].exp_perr_par : 1'b0, $sformatf("vec%0d", i));
      accept(vecs[i].hold, vecs[i].start_in_hold, vecs[i].exp_data, $sformatf("vec%0d", i));
    end

    // Abort during the second shift cycle.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    D = 1'b1;
    @(negedge clk);
    D = 1'b0;
    #2 CLR = 1'b1;
    #1;
    chk("abort async", {27'd0, sh_en, conv_clr, valid, busy, parity_err}, 32'd0);
    chk("abort data_out", {28'd0, data_out}, 32'd0);
    @(negedge clk);
    CLR = 1'b0;
    run_frame(4'h6, 1'b0, 4'h6, 1'b0, "post-abort");
    accept(0, 1'b0, 4'h6, "post-abort");

    // start and ready at the same edge in VALID complete the handshake only.
    run_frame(4'h9, 1'b0, 4'h9, (PAR == 1) ? 1'b0 : 1'b0, "simul");
    @(negedge clk);
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    start = 1'b0;
    chk("simul valid/busy", {30'd0, valid, busy}, 32'd0);
    @(negedge clk);
    chk("simul no new frame", {29'd0, busy, conv_clr, sh_en}, 32'd0);
    run_frame(4'h3, 1'b1, 4'h3, model_perr(4'h3, 1'b1), "simul-next");
    accept(0, 1'b0, 4'h3, "simul-next");

    // Randomized frames against the reference model.
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] b;
      logic         p;
      b = W'($urandom_range(0, (1 << W) - 1));
      p = 1'(($urandom) & 1);
      run_frame(b, p, b, model_perr(b, p), $sformatf("rnd%0d", i));
      accept($urandom_range(0, 3), 1'($urandom & 1), b, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule
